// File: rtl/moore_pattern_gen_pkg.sv
// Shared constants for the "1 followed by ZEROS 0s" pattern generator and its detector bench.
package moore_pattern_gen_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] MARK = 2'b01;
  localparam logic [1:0] GAP  = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  localparam int unsigned ZEROS_DEFAULT = 5;

endpackage

// File: rtl/down_counter_ld.sv
// Loadable down counter with synchronous clear; it stops at zero instead of wrapping.
module down_counter_ld #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         r,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         last
);

  always_ff @(posedge clk or posedge r) begin
    if (r)                         count <= '0;
    else if (clr)                  count <= '0;
    else if (load)                 count <= value;
    else if (dec && count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/moore_pattern_gen.sv
// Serial Moore pattern generator: repeat_n frames of one '1' marker followed by ZEROS '0' bits.
module moore_pattern_gen
  import moore_pattern_gen_pkg::*;
#(
  parameter int unsigned ZEROS = ZEROS_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       current
);

  localparam int unsigned GW = $clog2(ZEROS + 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             gap_load, gap_dec, gap_clr;
  logic             frm_load, frm_dec, frm_clr;
  logic [GW-1:0]    gap_count;
  logic [CNT_W-1:0] frm_count;
  logic             gap_zero, gap_last;
  logic             frm_zero, frm_last;

  down_counter_ld #(.W(GW)) u_gap_cnt (
    .clk   (clk),
    .r     (r),
    .clr   (gap_clr),
    .load  (gap_load),
    .value (GW'(ZEROS)),
    .dec   (gap_dec),
    .count (gap_count),
    .zero  (gap_zero),
    .last  (gap_last)
  );

  down_counter_ld #(.W(CNT_W)) u_frm_cnt (
    .clk   (clk),
    .r     (r),
    .clr   (frm_clr),
    .load  (frm_load),
    .value (repeat_n),
    .dec   (frm_dec),
    .count (frm_count),
    .zero  (frm_zero),
    .last  (frm_last)
  );

  always_ff @(posedge clk or posedge r) begin
    if (r) state <= IDLE;
    else   state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    gap_clr    = 1'b0;
    frm_load   = 1'b0;
    frm_dec    = 1'b0;
    frm_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (repeat_n != '0) begin
            next_state = MARK;
            frm_load   = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      MARK: begin
        if (abort) begin
          gap_clr = 1'b1;
          frm_clr = 1'b1;
        end else begin
          next_state = GAP;
          gap_load   = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          gap_clr = 1'b1;
          frm_clr = 1'b1;
        end else begin
          gap_dec = 1'b1;
          // A zero count here can only come from corruption; end the gap rather than stall.
          if (gap_last || gap_zero) begin
            frm_dec    = 1'b1;
            next_state = (frm_last || frm_zero) ? DONE : MARK;
          end else begin
            next_state = GAP;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign out     = (state == MARK);
  assign busy    = (state == MARK) || (state == GAP);
  assign done    = (state == DONE);
  assign current = state;

endmodule

// File: tb/tb_moore_pattern_gen.sv
// Bench for moore_pattern_gen: vector table, directed corner sequences and a random run against a frame-level model.
module tb_moore_pattern_gen;

  localparam int ZEROS = moore_pattern_gen_pkg::ZEROS_DEFAULT;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             r = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic             abort = 1'b0;
  logic             out, busy, done;
  logic [1:0]       current;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Frame-level model: position inside the current frame and frames still owed.
  bit m_active = 0;
  bit m_done = 0;
  int m_pos = 0;
  int m_left = 0;

  logic [5:0] hist = '0;
  int det_cyc[$];

  typedef struct {
    logic             s;
    logic [CNT_W-1:0] n;
    logic             a;
    logic             e_out;
    logic             e_busy;
    logic             e_done;
    logic [1:0]       e_cur;
  } vec_t;

  vec_t vecs[$];

  moore_pattern_gen #(.ZEROS(ZEROS), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .r        (r),
    .start    (start),
    .repeat_n (repeat_n),
    .abort    (abort),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .current  (current)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_pos = 0; m_left = 0;
  endtask

  task automatic model_edge();
    bit pd;
    pd = m_done;
    m_done = 0;
    if (m_active) begin
      if (abort) begin
        m_active = 0;
      end else begin
        m_pos++;
        if (m_pos == ZEROS + 1) begin
          m_pos = 0;
          m_left--;
          if (m_left == 0) begin
            m_active = 0;
            m_done = 1;
          end
        end
      end
    end else if (!pd && start && !abort) begin
      if (repeat_n == 0) m_done = 1;
      else begin
        m_active = 1; m_pos = 0; m_left = int'(repeat_n);
      end
    end
  endtask

  task automatic compare_model();
    int e_cur;
    e_cur = m_done ? 3 : (m_active ? ((m_pos == 0) ? 1 : 2) : 0);
    check("model_out", int'(out), int'(m_active && m_pos == 0));
    check("model_busy", int'(busy), int'(m_active));
    check("model_done", int'(done), int'(m_done));
    check("model_current", int'(current), e_cur);
  endtask

  // Drive inputs, take one edge, sample 1 ns later.
  task automatic step(input logic s, input logic [CNT_W-1:0] n, input logic a);
    start = s; repeat_n = n; abort = a;
    @(posedge clk);
    if (r) model_reset(); else model_edge();
    #1;
    cyc++;
    hist = {hist[4:0], out};
    if (hist == 6'b100000) det_cyc.push_back(cyc);
    compare_model();
  endtask

  task automatic run_until_done(input int from, input int limit, output int at);
    at = -1;
    for (int i = from + 1; i <= limit; i++) begin
      step(1'b0, '0, 1'b0);
      if (done === 1'b1) begin
        at = i;
        break;
      end
    end
  endtask

  initial begin
    int at;
    int first;
    bit saw_done;
    bit saw_out;

    // Reset held with start pulsed: nothing may leave IDLE.
    #6;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd3, 1'b0);
      check("rst_out", int'(out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_current", int'(current), 0);
    end
    r = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'd3, 1'b0);
    check("post_rst_idle", int'(current), 0);

    // Vector table: single frame, zero count, start in DONE, abort+start in IDLE.
    vecs.push_back('{1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01});
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10});
    vecs.push_back('{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11});
    vecs.push_back('{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    vecs.push_back('{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11});
    vecs.push_back('{1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    vecs.push_back('{1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
    vecs.push_back('{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].n, vecs[i].a);
      check($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].e_out));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
      check($sformatf("vec%0d_cur", i), int'(current), int'(vecs[i].e_cur));
    end

    // Three-frame burst seen through a 100000 window detector.
    det_cyc.delete();
    first = cyc;
    step(1'b1, 8'd3, 1'b0);
    run_until_done(1, 40, at);
    check("burst3_done_cycle", at, 19);
    check("burst3_detections", det_cyc.size(), 3);
    if (det_cyc.size() == 3) begin
      check("burst3_det_first", det_cyc[0] - first, 6);
      check("burst3_det_gap1", det_cyc[1] - det_cyc[0], 6);
      check("burst3_det_gap2", det_cyc[2] - det_cyc[1], 6);
    end
    step(1'b0, '0, 1'b0);

    // Abort in the third GAP cycle of frame 2.
    step(1'b1, 8'd4, 1'b0);
    for (int i = 2; i <= 10; i++) step(1'b0, '0, 1'b0);
    check("abort_pre_current", int'(current), 2);
    step(1'b0, '0, 1'b1);
    check("abort_out", int'(out), 0);
    check("abort_current", int'(current), 0);
    saw_done = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0, 1'b0);
      if (done) saw_done = 1;
    end
    check("abort_no_done", int'(saw_done), 0);
    step(1'b1, 8'd1, 1'b0);
    check("abort_restart_current", int'(current), 1);
    run_until_done(1, 20, at);
    check("abort_restart_done", at, 7);

    // Start with new count while busy is ignored.
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'd7, 1'b0);
    run_until_done(3, 100, at);
    check("busy_start_ignored_done", at, 13);
    step(1'b0, '0, 1'b0);

    // Async reset between edges while in MARK.
    step(1'b1, 8'd3, 1'b0);
    check("async_pre_out", int'(out), 1);
    #2 r = 1'b1;
    #1;
    check("async_out", int'(out), 0);
    check("async_busy", int'(busy), 0);
    check("async_current", int'(current), 0);
    model_reset();
    step(1'b0, '0, 1'b0);
    r = 1'b0;
    saw_out = 0;
    saw_done = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, '0, 1'b0);
      if (out) saw_out = 1;
      if (done) saw_done = 1;
    end
    check("async_stays_idle", int'(saw_out | saw_done), 0);

    // Largest count runs to completion without wrapping.
    step(1'b1, 8'd255, 1'b0);
    run_until_done(1, 2000, at);
    check("max_count_done", at, 255 * (ZEROS + 1) + 1);
    step(1'b0, '0, 1'b0);

    // Random traffic against the model, with occasional async resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        #1 r = 1'b1;
        #1;
        check("rand_async_out", int'(out), 0);
        model_reset();
        r = 1'b0;
      end
      step($urandom_range(0, 3) == 0, CNT_W'($urandom_range(0, 4)), $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
